// File: rtl/mono_pkg.sv
// mono_pkg: mode codes shared with the RGB-to-monochrome mapper, plus the
// state encoding of the mode controller.
package mono_pkg;

    // Mode codes as consumed by the output mapper
    localparam logic [1:0] MODE_COLOR = 2'b00;
    localparam logic [1:0] MODE_GREEN = 2'b01;
    localparam logic [1:0] MODE_AMBER = 2'b10;
    localparam logic [1:0] MODE_BW    = 2'b11;

    // Button classification states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } mono_state_e;

    // Next mode in the cycle colour -> green -> amber -> b/w -> colour
    function automatic logic [1:0] mode_next(input logic [1:0] mode);
        return mode + 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer for an active-low raw button followed by
// a stability counter. A new level is accepted once the synchronized input has
// differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
// press_stb / release_stb fire in the cycle the new level is accepted.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 285710
) (
    input  logic clk_vga,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_level,
    output logic press_stb,
    output logic release_stb
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_n;
    logic             sync2_n;
    logic             btn_s;
    logic [CNT_W-1:0] stable_cnt;
    logic             accept;

    assign btn_s  = ~sync2_n;
    assign accept = (btn_s != btn_level) && (stable_cnt == CNT_LAST);

    // Bring the asynchronous pad into clk_vga; flops reset to "released"
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            sync1_n <= 1'b1;
            sync2_n <= 1'b1;
        end else begin
            sync1_n <= btn_n;
            sync2_n <= sync1_n;
        end
    end

    // Count how long the input has disagreed with the accepted level
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            btn_level  <= 1'b0;
        end else if (btn_s == btn_level) begin
            stable_cnt <= '0;
        end else if (accept) begin
            stable_cnt <= '0;
            btn_level  <= btn_s;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // Edge strobes in the acceptance cycle
    always_comb begin
        press_stb   = accept && btn_s;
        release_stb = accept && !btn_s;
    end

endmodule

// File: rtl/mono_mode_ctrl.sv
// mono_mode_ctrl: turns a debounced joystick button into the 2-bit monochrome
// mode code. A short press steps the mode on release, a press held for
// LONG_FRAMES vsync pulses returns to colour. Every change is deferred to the
// start of vertical sync so the palette never switches mid-frame.
//
// Optional build macro MONO_MODE_DIRECT_EN adds mode_req / mode_req_valid so
// a hotkey decoder can request a specific mode; it outranks a pending step but
// not a pending long-press reset.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | button released, waiting for a debounced press
// ST_HELD | press accepted, counting frames; release = short press
// ST_LONG | long press registered, waiting for a debounced release
module mono_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 285710,
    parameter int LONG_FRAMES      = 60,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic       vga_vsync,
`ifdef MONO_MODE_DIRECT_EN
    input  logic [1:0] mode_req,
    input  logic       mode_req_valid,
`endif
    output logic [1:0] mono_mode,
    output logic       mode_changed
);

    import mono_pkg::*;

    localparam int              FR_W       = $clog2(LONG_FRAMES + 1);
    localparam logic [FR_W-1:0] FRAME_LAST = FR_W'(LONG_FRAMES);

    mono_state_e     state;
    mono_state_e     state_nx;

    logic            btn_level;
    logic            press_stb;
    logic            release_stb;

    logic            vs_active;
    logic            vs_prev;
    logic            vs_start;

    logic [FR_W-1:0] frame_cnt;
    logic            frame_clr;
    logic            frame_inc;
    logic            set_step;
    logic            set_reset;

    logic            pend_step;
    logic            pend_reset;
`ifdef MONO_MODE_DIRECT_EN
    logic            pend_direct;
    logic [1:0]      direct_mode;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_vga    (clk_vga),
        .rst_n      (rst_n),
        .btn_n      (btn_n),
        .btn_level  (btn_level),
        .press_stb  (press_stb),
        .release_stb(release_stb)
    );

    assign vs_active = (VSYNC_ACTIVE_LOW != 0) ? ~vga_vsync : vga_vsync;
    assign vs_start  = vs_active && !vs_prev;

    // Previous vsync level; starts "active" so no strobe fires right after reset
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev <= 1'b1;
        end else begin
            vs_prev <= vs_active;
        end
    end

    // State register
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; LONG exits on the level so a release that lands in
    // the same cycle as the long-press decision is not lost
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (press_stb) state_nx = ST_HELD;
            end
            ST_HELD: begin
                if (frame_cnt == FRAME_LAST) state_nx = ST_LONG;
                else if (release_stb)        state_nx = ST_IDLE;
            end
            ST_LONG: begin
                if (!btn_level) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: frame counter control and pending-flag requests
    always_comb begin
        frame_clr = 1'b0;
        frame_inc = 1'b0;
        set_step  = 1'b0;
        set_reset = 1'b0;
        case (state)
            ST_IDLE: begin
                frame_clr = press_stb;
            end
            ST_HELD: begin
                if (frame_cnt == FRAME_LAST) begin
                    set_reset = 1'b1;
                end else begin
                    frame_inc = vs_start;
                    set_step  = release_stb;
                end
            end
            default: ;
        endcase
    end

    // Frames seen while the button is held, saturating at LONG_FRAMES
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_clr) begin
            frame_cnt <= '0;
        end else if (frame_inc) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Apply pending requests at vsync start, then record new requests.
    // Requests raised in the apply cycle land after the apply and so wait
    // for the following frame.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            mono_mode    <= MODE_COLOR;
            mode_changed <= 1'b0;
            pend_step    <= 1'b0;
            pend_reset   <= 1'b0;
`ifdef MONO_MODE_DIRECT_EN
            pend_direct  <= 1'b0;
            direct_mode  <= MODE_COLOR;
`endif
        end else begin
            mode_changed <= 1'b0;
            if (vs_start) begin
                if (pend_reset) begin
                    mono_mode    <= MODE_COLOR;
                    mode_changed <= (mono_mode != MODE_COLOR);
                    pend_reset   <= 1'b0;
                    pend_step    <= 1'b0;
`ifdef MONO_MODE_DIRECT_EN
                    pend_direct  <= 1'b0;
`endif
                end
`ifdef MONO_MODE_DIRECT_EN
                else if (pend_direct) begin
                    mono_mode    <= direct_mode;
                    mode_changed <= (mono_mode != direct_mode);
                    pend_direct  <= 1'b0;
                    pend_step    <= 1'b0;
                end
`endif
                else if (pend_step) begin
                    mono_mode    <= mode_next(mono_mode);
                    mode_changed <= 1'b1;
                    pend_step    <= 1'b0;
                end
            end

            if (set_reset) begin
                pend_reset <= 1'b1;
                pend_step  <= 1'b0;
            end else if (set_step) begin
                pend_step  <= 1'b1;
            end

`ifdef MONO_MODE_DIRECT_EN
            if (mode_req_valid) begin
                pend_direct <= 1'b1;
                direct_mode <= mode_req;
                pend_step   <= 1'b0;
            end
`endif
        end
    end

endmodule
